encoder_round_ctrl: RTL

Sequencing controller for the matrix-encoder datapath (25-bit lines × 64-line state, 24 rounds). Each round it runs the five stage engines in fixed order: column parity, rotate, permute, revaluate, add-round-constant. It drives each stage enable and waits for that stage's done. It also owns the round count, input-register load and result handshake.

---
 rtl/encoder_pkg.sv | 79 +++++++
 rtl/stage_watchdog.sv | 32 +++
 rtl/encoder_round_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the matrix-encoder round controller.
// Optional build macro: STAGE_TIMEOUT_EN adds the ERR state used by the stage watchdog.
package encoder_pkg;

  // Datapath geometry, kept here so every block agrees on it.
  localparam int LINE_W         = 25;
  localparam int NUM_LINES      = 64;
  localparam int DEF_NUM_ROUNDS = 24;

  // Stage indices; bit positions in the stage enable/done vectors.
  localparam int NUM_STAGES = 5;
  localparam int STG_COLP   = 0;
  localparam int STG_ROT    = 1;
  localparam int STG_PERM   = 2;
  localparam int STG_REVAL  = 3;
  localparam int STG_ADDRC  = 4;

`ifdef STAGE_TIMEOUT_EN
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_COLP  = 4'd2,
    S_ROT   = 4'd3,
    S_PERM  = 4'd4,
    S_REVAL = 4'd5,
    S_ADDRC = 4'd6,
    S_NEXT  = 4'd7,
    S_FIN   = 4'd8,
    S_ERR   = 4'd9
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_COLP  = 4'd2,
    S_ROT   = 4'd3,
    S_PERM  = 4'd4,
    S_REVAL = 4'd5,
    S_ADDRC = 4'd6,
    S_NEXT  = 4'd7,
    S_FIN   = 4'd8
  } state_t;
`endif

  // One-hot stage enable pattern that belongs to a state (zero outside stages).
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input state_t s);
    logic [NUM_STAGES-1:0] v;
    v = '0;
    case (s)
      S_COLP:  v[STG_COLP]  = 1'b1;
      S_ROT:   v[STG_ROT]   = 1'b1;
      S_PERM:  v[STG_PERM]  = 1'b1;
      S_REVAL: v[STG_REVAL] = 1'b1;
      S_ADDRC: v[STG_ADDRC] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Fixed stage order; the last stage hands over to the round-advance state.
  function automatic state_t stage_after(input state_t s);
    state_t n;
    case (s)
      S_COLP:  n = S_ROT;
      S_ROT:   n = S_PERM;
      S_PERM:  n = S_REVAL;
      S_REVAL: n = S_ADDRC;
      default: n = S_NEXT;
    endcase
    return n;
  endfunction

  // States during which an encode is in flight.
  function automatic logic is_busy_state(input state_t s);
    return (s == S_LOAD) || (s == S_COLP) || (s == S_ROT) || (s == S_PERM) ||
           (s == S_REVAL) || (s == S_ADDRC) || (s == S_NEXT);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage residency counter: cleared on every stage entry, counts stage
// cycles and flags the cycle in which the stay reaches LIMIT cycles.
// Only instantiated when STAGE_TIMEOUT_EN is defined.
module stage_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  // Current cycle is the LIMIT-th cycle of the stay.
  assign expired = tick && (count_reg == CW'(LIMIT - 1));

  // Residency counter; saturates once expired so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (tick && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/encoder_round_ctrl.sv
// Round sequencer for the matrix encoder: load, five stages per round in
// fixed order, round advance, result handshake. All outputs are registered
// and decoded from the next state, so they line up with the state they
// belong to. Optional build macro: STAGE_TIMEOUT_EN (per-stage watchdog, ERR).
module encoder_round_ctrl
  import encoder_pkg::*;
#(
  parameter int NUM_ROUNDS     = DEF_NUM_ROUNDS,
  parameter int ROUND_W        = 5,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               inreg_en,
  output logic               cnt_rst_24,
  output logic               cnt_en_24,
  output logic               colParity_en,
  output logic               rotate_en,
  output logic               permute_en,
  output logic               revalute_en,
  output logic               addRC_en,
  input  logic               done1,
  input  logic               done2,
  input  logic               done3,
  input  logic               done4,
  input  logic               done5,
  output logic [ROUND_W-1:0] round_idx,
  output logic               first_round,
  output logic               result_valid,
  input  logic               result_ack,
  output logic               err
);

  state_t state_reg, state_next;

  logic [NUM_STAGES-1:0] stage_en_reg, stage_en_next;
  logic [NUM_STAGES-1:0] stage_en_prev_reg;
  logic [NUM_STAGES-1:0] done_vec, done_qual;
  logic [ROUND_W-1:0]    round_reg, round_next;

  logic busy_reg, busy_next;
  logic inreg_en_reg, inreg_en_next;
  logic cnt_rst_reg, cnt_rst_next;
  logic cnt_en_reg, cnt_en_next;
  logic first_round_reg, first_round_next;
  logic result_valid_reg, result_valid_next;
  logic err_reg, err_next;
  logic stage_done;

  // A done only counts for the active stage and only once its enable has
  // been up for at least one full cycle, which also enforces 2-cycle residency.
  assign done_vec   = {done5, done4, done3, done2, done1};
  assign done_qual  = done_vec & stage_en_reg & stage_en_prev_reg;
  assign stage_done = |done_qual;

`ifdef STAGE_TIMEOUT_EN
  logic wd_clear, wd_tick, wd_expired;

  assign wd_clear = (state_next != state_reg);
  assign wd_tick  = |stage_en_reg;

  stage_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_stage_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .tick   (wd_tick),
    .expired(wd_expired)
  );
`endif

  // Next-state logic plus the next values of every registered output.
  always_comb begin
    state_next        = state_reg;
    round_next        = round_reg;
    result_valid_next = result_valid_reg;

    if (result_valid_reg && result_ack) begin
      result_valid_next = 1'b0;
    end

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: state_next = S_COLP;
      S_COLP, S_ROT, S_PERM, S_REVAL, S_ADDRC: begin
        if (stage_done) begin
          state_next = stage_after(state_reg);
        end
`ifdef STAGE_TIMEOUT_EN
        else if (wd_expired) begin
          state_next = S_ERR;
        end
`endif
      end
      S_NEXT: begin
        if (round_reg == ROUND_W'(NUM_ROUNDS - 1)) begin
          state_next = S_FIN;
        end else begin
          round_next = round_reg + 1'b1;
          state_next = S_COLP;
        end
      end
      S_FIN: state_next = S_IDLE;
`ifdef STAGE_TIMEOUT_EN
      S_ERR: state_next = S_ERR;
`endif
      default: state_next = S_IDLE;
    endcase

    // A new run restarts the round count and drops any unclaimed result.
    if (state_next == S_LOAD) begin
      round_next        = '0;
      result_valid_next = 1'b0;
    end
    if (state_next == S_FIN) begin
      result_valid_next = 1'b1;
    end

    stage_en_next    = stage_onehot(state_next);
    busy_next        = is_busy_state(state_next);
    inreg_en_next    = (state_next == S_LOAD);
    cnt_rst_next     = (state_next == S_LOAD);
    cnt_en_next      = (state_next == S_NEXT);
    first_round_next = busy_next && (round_next == '0);
`ifdef STAGE_TIMEOUT_EN
    err_next         = (state_next == S_ERR);
`else
    err_next         = 1'b0;
`endif
  end

  // State register and registered outputs; reset clears everything at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      round_reg         <= '0;
      stage_en_reg      <= '0;
      stage_en_prev_reg <= '0;
      busy_reg          <= 1'b0;
      inreg_en_reg      <= 1'b0;
      cnt_rst_reg       <= 1'b0;
      cnt_en_reg        <= 1'b0;
      first_round_reg   <= 1'b0;
      result_valid_reg  <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      state_reg         <= state_next;
      round_reg         <= round_next;
      stage_en_reg      <= stage_en_next;
      stage_en_prev_reg <= stage_en_reg;
      busy_reg          <= busy_next;
      inreg_en_reg      <= inreg_en_next;
      cnt_rst_reg       <= cnt_rst_next;
      cnt_en_reg        <= cnt_en_next;
      first_round_reg   <= first_round_next;
      result_valid_reg  <= result_valid_next;
      err_reg           <= err_next;
    end
  end

  assign busy         = busy_reg;
  assign inreg_en     = inreg_en_reg;
  assign cnt_rst_24   = cnt_rst_reg;
  assign cnt_en_24    = cnt_en_reg;
  assign colParity_en = stage_en_reg[STG_COLP];
  assign rotate_en    = stage_en_reg[STG_ROT];
  assign permute_en   = stage_en_reg[STG_PERM];
  assign revalute_en  = stage_en_reg[STG_REVAL];
  assign addRC_en     = stage_en_reg[STG_ADDRC];
  assign round_idx    = round_reg;
  assign first_round  = first_round_reg;
  assign result_valid = result_valid_reg;
  assign err          = err_reg;

endmodule
